// File: rtl/seg7_pkg.sv
//------------------------------------------------------------------------------
// seg7_pkg
//   Definitions shared by the dual-digit 7-segment PMOD driver:
//     - seg7_state_t : display sequencer state encoding
//     - SEG_TABLE    : active-high gfedcba glyphs for hex digits 0..F
//     - SEG_OFF      : active-high "all segments dark" pattern
//     - SEL_RIGHT / SEL_LEFT : values of the digit-select bit
//   No ports (package).
//------------------------------------------------------------------------------
package seg7_pkg;

   // Display sequence: BLANK_R -> SHOW_R -> BLANK_L -> SHOW_L -> BLANK_R.
   typedef enum logic [1:0] {
      BLANK_R = 2'd0,
      SHOW_R  = 2'd1,
      BLANK_L = 2'd2,
      SHOW_L  = 2'd3
   } seg7_state_t;

   // Packed so that SEG_TABLE[n] is the glyph for hex digit n (bit0 = a).
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39,   // F E D C
      7'h7C, 7'h77, 7'h6F, 7'h7F,   // B A 9 8
      7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
      7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
   };

   localparam logic [6:0] SEG_OFF   = 7'h00;
   localparam logic       SEL_RIGHT = 1'b0;
   localparam logic       SEL_LEFT  = 1'b1;

endpackage : seg7_pkg

// File: rtl/hex_to_seg7.sv
//------------------------------------------------------------------------------
// hex_to_seg7
//   Purely combinational hex digit to 7-segment glyph decoder.
//   Output is active-high; polarity is handled by the caller.
// Ports:
//   nibble  in  4  hex digit to decode
//   seg     out 7  segments a..g, bit0 = a, 1 = lit
//------------------------------------------------------------------------------
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule : hex_to_seg7

// File: rtl/seg7_driver.sv
//------------------------------------------------------------------------------
// seg7_driver
//   Time-multiplexes two hex digits onto a dual-digit 7-segment PMOD.
//   Each frame is BLANK_R, SHOW_R, BLANK_L, SHOW_L; the blank phases keep all
//   segments dark while the digit select is switched, preventing ghosting.
//   New values arrive through a one-deep valid/ready slot and are promoted to
//   the displayed value only at a frame boundary, so both digits always show
//   the same value.
// Parameters:
//   SHOW_CYCLES    clocks each digit is lit per frame (>=1)
//   BLANK_CYCLES   clocks of darkness before each digit (>=1)
//   SEG_ACTIVE_LOW 1: a lit segment drives 0 on the pin
// Ports:
//   clk          in   1  system clock
//   rst          in   1  asynchronous reset, active-high
//   data_in      in   8  [3:0] right digit, [7:4] left digit
//   data_valid   in   1  data_in valid this cycle
//   data_ready   out  1  pending slot free
//   lz_en        in   1  blank left digit when it is zero
//   frame_start  out  1  one-cycle pulse in the first BLANK_R cycle of a frame
//   ss_out       out  8  [6:0] segments a..g, [7] digit select (1 = left)
//------------------------------------------------------------------------------
module seg7_driver
   import seg7_pkg::*;
#(
   parameter int SHOW_CYCLES    = 4096,
   parameter int BLANK_CYCLES   = 64,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   input  logic       lz_en,
   output logic       frame_start,
   output logic [7:0] ss_out
);

   localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   // Pin-level polarity mask for the segment bits; the select bit is never inverted.
   localparam logic [6:0] POL_MASK = {7{SEG_ACTIVE_LOW}};
   localparam logic [7:0] SS_RESET = {SEL_RIGHT, SEG_OFF ^ POL_MASK};

   seg7_state_t      state;
   seg7_state_t      state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [7:0]       disp;
   logic [7:0]       pending;
   logic             pending_full;

   logic             boundary;
   logic             accept;
   logic [3:0]       nibble;
   logic [6:0]       glyph;
   logic [6:0]       seg_next;
   logic             sel_next;
   logic [7:0]       ss_next;

   assign data_ready = !pending_full;
   assign accept     = data_valid && !pending_full;

   //---------------------------------------------------------------------------
   // Phase sequencing: the counter restarts from zero on every state change.
   //---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      cnt_next   = cnt + 1'b1;
      boundary   = 1'b0;
      unique case (state)
         BLANK_R: if (cnt == BLANK_LAST) begin
            state_next = SHOW_R;
            cnt_next   = '0;
         end
         SHOW_R: if (cnt == SHOW_LAST) begin
            state_next = BLANK_L;
            cnt_next   = '0;
         end
         BLANK_L: if (cnt == BLANK_LAST) begin
            state_next = SHOW_L;
            cnt_next   = '0;
         end
         SHOW_L: if (cnt == SHOW_LAST) begin
            state_next = BLANK_R;
            cnt_next   = '0;
            boundary   = 1'b1;
         end
         default: begin
            state_next = BLANK_R;
            cnt_next   = '0;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Output pattern for the upcoming cycle. It is derived from the next state
   // so the registered ss_out lines up with the state register. disp is stable
   // whenever a digit is being lit (it only changes on entry to BLANK_R).
   //---------------------------------------------------------------------------
   assign nibble = (state_next == SHOW_L) ? disp[7:4] : disp[3:0];

   hex_to_seg7 u_decode (
      .nibble (nibble),
      .seg    (glyph)
   );

   always_comb begin
      seg_next = SEG_OFF;
      sel_next = SEL_RIGHT;
      unique case (state_next)
         BLANK_R: begin
            seg_next = SEG_OFF;
            sel_next = SEL_RIGHT;
         end
         SHOW_R: begin
            seg_next = glyph;
            sel_next = SEL_RIGHT;
         end
         BLANK_L: begin
            seg_next = SEG_OFF;
            sel_next = SEL_LEFT;
         end
         SHOW_L: begin
            // Leading-zero suppression follows lz_en live, with no latching.
            seg_next = (lz_en && (disp[7:4] == 4'h0)) ? SEG_OFF : glyph;
            sel_next = SEL_LEFT;
         end
         default: begin
            seg_next = SEG_OFF;
            sel_next = SEL_RIGHT;
         end
      endcase
      ss_next = {sel_next, seg_next ^ POL_MASK};
   end

   //---------------------------------------------------------------------------
   // State, handshake slot and display registers.
   // An accept can coincide with the boundary only when the slot was empty,
   // in which case disp is left alone and the value waits a full frame.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= BLANK_R;
         cnt          <= '0;
         disp         <= 8'h00;
         pending      <= 8'h00;
         pending_full <= 1'b0;
         frame_start  <= 1'b0;
         ss_out       <= SS_RESET;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         frame_start <= boundary;
         ss_out      <= ss_next;
         if (boundary && pending_full) begin
            disp         <= pending;
            pending_full <= 1'b0;
         end else if (accept) begin
            pending      <= data_in;
            pending_full <= 1'b1;
         end
      end
   end

endmodule : seg7_driver

// File: rtl/seg7_pmod_driver.sv
//------------------------------------------------------------------------------
// seg7_pmod_driver
//   Top level for the dual-digit 7-segment PMOD on header P1A. Wraps the
//   multiplexing driver and routes its output onto the ss_top header bus.
// Parameters: SHOW_CYCLES, BLANK_CYCLES, SEG_ACTIVE_LOW (see seg7_driver).
// Ports:
//   clk          in   1  system clock (12 MHz on iCEBreaker)
//   rst          in   1  asynchronous reset, active-high
//   data_in      in   8  [3:0] right digit, [7:4] left digit
//   data_valid   in   1  data_in valid this cycle
//   data_ready   out  1  pending slot free; transfer on valid && ready
//   lz_en        in   1  blank left digit when it is zero
//   frame_start  out  1  one-cycle pulse when a new frame begins
//   ss_out       out  8  [6:0] segments a..g (bit0 = a), [7] digit select
//------------------------------------------------------------------------------
module seg7_pmod_driver
   import seg7_pkg::*;
#(
   parameter int SHOW_CYCLES    = 4096,
   parameter int BLANK_CYCLES   = 64,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   input  logic       lz_en,
   output logic       frame_start,
   output logic [7:0] ss_out
);

   logic [7:0] ss_top;

   seg7_driver #(
      .SHOW_CYCLES    (SHOW_CYCLES),
      .BLANK_CYCLES   (BLANK_CYCLES),
      .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
   ) u_driver (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .lz_en       (lz_en),
      .frame_start (frame_start),
      .ss_out      (ss_top)
   );

   assign ss_out = ss_top;

endmodule : seg7_pmod_driver

// File: tb/tb_seg7_pmod_driver.sv
//------------------------------------------------------------------------------
// tb_seg7_pmod_driver
//   Drives two instances (segments active-high and active-low) with the same
//   stimulus and compares them every cycle against a frame-position model:
//   the expected output is a function of (cycles since reset) mod frame length,
//   the displayed value and the previous-cycle lz_en.
//------------------------------------------------------------------------------
module tb_seg7_pmod_driver;

   localparam int SHOW  = 8;
   localparam int BLANK = 2;
   localparam int FRAME = 2 * (SHOW + BLANK);

   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic       lz_en = 1'b0;

   logic       data_ready;
   logic       frame_start;
   logic [7:0] ss_out;
   logic       data_ready_al;
   logic       frame_start_al;
   logic [7:0] ss_out_al;

   always #5 clk = ~clk;

   seg7_pmod_driver #(
      .SHOW_CYCLES    (SHOW),
      .BLANK_CYCLES   (BLANK),
      .SEG_ACTIVE_LOW (1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .lz_en       (lz_en),
      .frame_start (frame_start),
      .ss_out      (ss_out)
   );

   seg7_pmod_driver #(
      .SHOW_CYCLES    (SHOW),
      .BLANK_CYCLES   (BLANK),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut_al (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (data_ready_al),
      .lz_en       (lz_en),
      .frame_start (frame_start_al),
      .ss_out      (ss_out_al)
   );

   // Reference model state
   int         c;        // clock edges since reset release
   logic [7:0] m_disp;
   logic [7:0] m_pend;
   bit         m_full;
   bit         m_lz;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h (cycle %0d)", tag, got, exp, c);
      end
   endtask

   function automatic logic [7:0] exp_ss();
      int pos;
      pos = c % FRAME;
      if (pos < BLANK)
         return 8'h00;
      else if (pos < BLANK + SHOW)
         return {1'b0, GLYPH[m_disp[3:0]]};
      else if (pos < 2 * BLANK + SHOW)
         return 8'h80;
      else if (m_lz && (m_disp[7:4] == 4'h0))
         return 8'h80;
      else
         return {1'b1, GLYPH[m_disp[7:4]]};
   endfunction

   task automatic model_reset();
      c      = 0;
      m_disp = 8'h00;
      m_pend = 8'h00;
      m_full = 1'b0;
      m_lz   = 1'b0;
   endtask

   task automatic check_all();
      logic [7:0] e;
      e = exp_ss();
      check("ss_out", ss_out, e);
      check("ss_out_al", ss_out_al, e ^ 8'h7F);
      check("data_ready", {7'b0, data_ready}, {7'b0, !m_full});
      check("frame_start", {7'b0, frame_start}, {7'b0, ((c % FRAME) == 0) && (c >= FRAME)});
   endtask

   // One clock: drive inputs, advance the model at the edge, check at negedge.
   task automatic cycle(input bit v, input logic [7:0] d, input bit lz, output bit acc);
      data_valid = v;
      data_in    = d;
      lz_en      = lz;
      @(posedge clk);
      acc = v && !m_full;
      if (((c % FRAME) == FRAME - 1) && m_full) begin
         m_disp = m_pend;
         m_full = 1'b0;
      end else if (acc) begin
         m_pend = d;
         m_full = 1'b1;
      end
      m_lz = lz;
      c++;
      if (acc)
         $display("accept data=%02h lz=%0b at cycle %0d", d, lz, c);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n, input bit lz);
      bit acc;
      for (int k = 0; k < n; k++)
         cycle(1'b0, 8'($urandom), lz, acc);
   endtask

   // Hold valid until accepted, bounded by a few frames.
   task automatic send(input logic [7:0] d, input bit lz);
      bit acc;
      acc = 1'b0;
      for (int k = 0; k < 3 * FRAME && !acc; k++)
         cycle(1'b1, d, lz, acc);
      check("accept", {7'b0, acc}, 8'h01);
   endtask

   task automatic idle_until(input int pos);
      bit acc;
      for (int k = 0; k < 4 * FRAME && (((c % FRAME) != pos) || m_full); k++)
         cycle(1'b0, 8'h00, 1'b0, acc);
      check("reach_pos", {7'b0, ((c % FRAME) == pos) && !m_full}, 8'h01);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;

      // Reset state, then the idle pattern 00/3F/80/BF.
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;
      check_all();
      idle(45, 1'b0);

      // Single-cycle accept mid-frame.
      idle_until(5);
      cycle(1'b1, 8'hA5, 1'b0, acc);
      idle(45, 1'b0);

      // Back-to-back values: second one stalls until the boundary.
      idle_until(7);
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      idle(45, 1'b0);

      // Leading-zero blanking on and off.
      send(8'h07, 1'b1);
      idle(45, 1'b1);
      idle(40, 1'b0);

      // Asynchronous reset during SHOW_L with the slot full.
      idle_until(13);
      cycle(1'b1, 8'h5C, 1'b0, acc);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all();
      idle(45, 1'b0);

      // Random traffic with random lz_en.
      for (int k = 0; k < 1500; k++)
         cycle(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 1)), acc);

      // Every value 00..FF, one per frame.
      for (int i = 0; i < 256; i++)
         send(8'(i), 1'b0);
      idle(45, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_seg7_pmod_driver
